// File: rtl/axi_wr_ctrl_pkg.sv
// axi_wr_ctrl_pkg: shared CPU AXI header -- write-controller state encoding, RESP_OKAY and default AXI ID.
package axi_wr_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2
    } state_t;
    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [3:0] AXI_ID_DEFAULT = 4'd1;
endpackage

// File: rtl/axi_wr_ctrl_if.sv
// axi_wr_ctrl_if: single-beat AXI write bus (AW, W, B channels).
// master: drives awid/awaddr/awsize/awvalid, wdata/wstrb/wlast/wvalid, bready.
// slave:  drives awready, wready, bid/bresp/bvalid.
interface axi_wr_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [3:0]            awid;
    logic [31:0]           awaddr;
    logic [2:0]            awsize;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [3:0]            bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    modport master (
        output awid, awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bid, bresp, bvalid
    );
    modport slave (
        input  awid, awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_wr_ctrl.sv
// axi_wr_ctrl: pops one store-buffer entry at a time and issues it as a single-beat AXI write.
// Ports: clk/reset (sync, active-high); req_* store-buffer head (req_ready is the pop strobe);
// axi master bus; busy/busy_addr for read-after-write blocking; wr_done/wr_err completion pulses.
module axi_wr_ctrl
    import axi_wr_ctrl_pkg::*;
#(
    parameter logic [3:0] AXI_ID     = AXI_ID_DEFAULT,
    parameter int         DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [3:0]            req_strb,
    input  logic [2:0]            req_size,
    axi_wr_ctrl_if.master         axi,
    output logic                  busy,
    output logic [31:0]           busy_addr,
    output logic                  wr_done,
    output logic                  wr_err
);
    state_t                state, state_nx;
    logic                  aw_done, w_done;
    logic                  aw_fire, w_fire;
    logic [31:0]           addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [3:0]            strb_q;
    logic [2:0]            size_q;
    // Handshakes derived from state rather than the valid outputs to keep the comb path loop-free.
    assign aw_fire = (state == SEND) & ~aw_done & axi.awready;
    assign w_fire  = (state == SEND) & ~w_done & axi.wready;
    assign axi.awid   = AXI_ID;
    assign axi.awaddr = addr_q;
    assign axi.awsize = size_q;
    assign axi.wdata  = data_q;
    assign axi.wstrb  = strb_q;
    assign axi.wlast  = 1'b1;
    assign busy       = state != IDLE;
    assign busy_addr  = addr_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            size_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                addr_q  <= req_addr;
                data_q  <= req_data;
                strb_q  <= req_strb;
                size_q  <= req_size;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_fire) aw_done <= 1'b1;
                if (w_fire) w_done <= 1'b1;
            end
        end
    end
    always_comb begin
        state_nx    = state;
        req_ready   = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        wr_done     = 1'b0;
        wr_err      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                state_nx  = req_valid ? SEND : IDLE;
            end
            SEND: begin
                axi.awvalid = ~aw_done;
                axi.wvalid  = ~w_done;
                // Count a handshake landing this cycle so both-done moves on without an extra cycle.
                state_nx    = ((aw_done | aw_fire) & (w_done | w_fire)) ? RESP : SEND;
            end
            RESP: begin
                axi.bready = 1'b1;
                // Completion pulses are suppressed while reset abandons the write.
                wr_done    = axi.bvalid & ~reset;
                wr_err     = axi.bvalid & ~reset & ((axi.bresp != RESP_OKAY) | (axi.bid != AXI_ID));
                state_nx   = axi.bvalid ? IDLE : RESP;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_wr_ctrl.sv
// tb_axi_wr_ctrl: directed stimulus with a scoreboard; the monitor pops expected AW/W/B results as the DUT presents them.
module tb_axi_wr_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_strb = '0;
    logic [2:0]  req_size = '0;
    logic        busy;
    logic [31:0] busy_addr;
    logic        wr_done;
    logic        wr_err;
    int pass_cnt = 0, total_cnt = 0, cyc = 0, done_cnt = 0, nd = 0;
    int aw_cyc = -1, w_cyc = -1, done_cyc = -1;
    int aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [1:0]  b_resp = 2'b00;
    logic [3:0]  b_id = 4'd1;
    logic [34:0] aw_q[$];
    logic [35:0] w_q[$];
    logic        b_q[$];
    axi_wr_ctrl_if #(.DATA_WIDTH(32)) bus();
    axi_wr_ctrl #(.AXI_ID(4'd1), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb), .req_size(req_size),
        .axi(bus.master), .busy(busy), .busy_addr(busy_addr), .wr_done(wr_done), .wr_err(wr_err)
    );
    assign bus.bid   = b_id;
    assign bus.bresp = b_resp;
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask
    task automatic fail(input string name);
        total_cnt++;
        $display("FAIL %s: got event expected none at cycle %0d", name, cyc);
    endtask
    // Slave: each ready rises once its valid has been waiting the configured number of cycles.
    initial begin
        int n;
        n = 0;
        bus.awready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.awvalid) begin bus.awready = (n >= aw_delay); n++; end
            else begin bus.awready = 1'b0; n = 0; end
        end
    end
    initial begin
        int n;
        n = 0;
        bus.wready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.wvalid) begin bus.wready = (n >= w_delay); n++; end
            else begin bus.wready = 1'b0; n = 0; end
        end
    end
    initial begin
        int n;
        n = 0;
        bus.bvalid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.bready) begin bus.bvalid = (n >= b_delay); n++; end
            else begin bus.bvalid = 1'b0; n = 0; end
        end
    end
    // Monitor / scoreboard
    initial begin
        logic        pav, pwv, chk_rdy, eb;
        logic [31:0] pa, pd, exp_ba;
        logic [34:0] ea;
        logic [35:0] ew;
        pav = 0; pwv = 0; chk_rdy = 0; pa = 0; pd = 0; exp_ba = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pav = 0; pwv = 0; chk_rdy = 0;
            end else begin
                if (pav) check("aw_hold", {bus.awvalid, bus.awaddr}, {1'b1, pa});
                if (pwv) check("w_hold", {bus.wvalid, bus.wdata}, {1'b1, pd});
                if (chk_rdy) check("ready_after_b", req_ready, 1'b1);
                if (busy) check("busy_addr", busy_addr, exp_ba);
                if ((bus.awvalid || bus.wvalid) && bus.bready) fail("bready_early");
                if (wr_err && !wr_done) fail("wr_err_alone");
                if (bus.awvalid && bus.awready) begin
                    aw_cyc = cyc;
                    if (aw_q.size() == 0) fail("aw_unexpected");
                    else begin
                        ea = aw_q.pop_front();
                        check("aw_payload", {bus.awsize, bus.awaddr}, ea);
                        check("awid", bus.awid, 4'd1);
                    end
                end
                if (bus.wvalid && bus.wready) begin
                    w_cyc = cyc;
                    if (w_q.size() == 0) fail("w_unexpected");
                    else begin
                        ew = w_q.pop_front();
                        check("w_payload", {bus.wstrb, bus.wdata}, ew);
                        check("wlast", bus.wlast, 1'b1);
                    end
                end
                chk_rdy = wr_done;
                if (wr_done) begin
                    done_cyc = cyc;
                    done_cnt++;
                    if (b_q.size() == 0) fail("done_unexpected");
                    else begin
                        eb = b_q.pop_front();
                        check("wr_err", wr_err, eb);
                    end
                end
                if (req_valid && req_ready) exp_ba = req_addr;
                pav = bus.awvalid && !bus.awready;
                pa  = bus.awaddr;
                pwv = bus.wvalid && !bus.wready;
                pd  = bus.wdata;
            end
        end
    end
    // Call at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [2:0] z, input logic err, output int acc);
        aw_q.push_back({z, a});
        w_q.push_back({s, d});
        b_q.push_back(err);
        nd++;
        req_addr = a; req_data = d; req_strb = s; req_size = z; req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 20 && acc < 0; i++) begin
            @(negedge clk);
            if (req_ready) acc = cyc;
        end
        if (acc < 0) fail("accept_timeout");
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask
    task automatic wait_done();
        for (int i = 0; i < 40 && done_cnt < nd; i++) @(negedge clk);
        if (done_cnt < nd) fail("done_timeout");
        @(posedge clk); #1;
    endtask
    initial begin
        int a, a2, d0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_awvalid", bus.awvalid, 1'b0);
        check("rst_wvalid", bus.wvalid, 1'b0);
        check("rst_bready", bus.bready, 1'b0);
        check("rst_wr_done", wr_done, 1'b0);
        check("rst_wr_err", wr_err, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        // Basic write, all readies immediate
        issue(32'h1C00_0010, 32'hDEAD_BEEF, 4'hF, 3'd2, 1'b0, a);
        wait_done();
        check("t1_aw_cyc", aw_cyc - a, 1);
        check("t1_w_cyc", w_cyc - a, 1);
        check("t1_done_cyc", done_cyc - a, 2);
        // awready 3 cycles late, wready immediate
        aw_delay = 3;
        issue(32'h0000_1234, 32'h1122_3344, 4'h3, 3'd1, 1'b0, a);
        @(negedge clk);
        @(negedge clk);
        check("t2_wvalid_dropped", bus.wvalid, 1'b0);
        check("t2_awvalid_held", bus.awvalid, 1'b1);
        check("t2_bready_low", bus.bready, 1'b0);
        @(posedge clk); #1;
        wait_done();
        check("t2_w_cyc", w_cyc - a, 1);
        check("t2_aw_cyc", aw_cyc - a, 4);
        check("t2_done_cyc", done_cyc - a, 5);
        // wready before awready
        aw_delay = 2; w_delay = 0;
        issue(32'h0000_2000, 32'hCAFE_F00D, 4'h1, 3'd0, 1'b0, a);
        wait_done();
        check("t3a_aw_cyc", aw_cyc - a, 3);
        check("t3a_done_cyc", done_cyc - a, 4);
        // both handshakes in the same cycle
        aw_delay = 1; w_delay = 1;
        issue(32'h0000_3000, 32'h0BAD_F00D, 4'hC, 3'd1, 1'b0, a);
        wait_done();
        check("t3b_aw_cyc", aw_cyc - a, 2);
        check("t3b_w_cyc", w_cyc - a, 2);
        check("t3b_done_cyc", done_cyc - a, 3);
        // error responses
        aw_delay = 0; w_delay = 0; b_resp = 2'b10;
        issue(32'h0000_4000, 32'h5555_AAAA, 4'hF, 3'd2, 1'b1, a);
        wait_done();
        b_resp = 2'b00; b_id = 4'd3;
        issue(32'h0000_5000, 32'hAAAA_5555, 4'hF, 3'd2, 1'b1, a);
        wait_done();
        b_id = 4'd1;
        b_delay = 2;
        issue(32'h0000_6000, 32'h0123_4567, 4'hF, 3'd2, 1'b0, a);
        wait_done();
        check("t4_late_b_done_cyc", done_cyc - a, 4);
        b_delay = 0;
        // reset during SEND
        aw_delay = 5;
        d0 = done_cnt;
        issue(32'h0000_7000, 32'h7777_7777, 4'hF, 3'd2, 1'b0, a);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_busy", busy, 1'b0);
        check("t5_awvalid", bus.awvalid, 1'b0);
        check("t5_wvalid", bus.wvalid, 1'b0);
        check("t5_wr_done", wr_done, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        aw_q.delete();
        w_q.delete();
        b_q.delete();
        nd = d0;
        repeat (3) @(negedge clk);
        check("t5_no_done", done_cnt, d0);
        @(posedge clk); #1;
        aw_delay = 0;
        issue(32'h0000_8000, 32'h8888_0001, 4'hF, 3'd2, 1'b0, a);
        wait_done();
        check("t5_fresh_done_cyc", done_cyc - a, 2);
        // back-to-back
        issue(32'h1000_0100, 32'hA5A5_0001, 4'hF, 3'd2, 1'b0, a);
        issue(32'h1000_0200, 32'hA5A5_0002, 4'hF, 3'd2, 1'b0, a2);
        wait_done();
        check("t6_turnaround", a2 - a, 3);
        check("t6_done_cnt", done_cnt, nd);
        check("aw_q_empty", aw_q.size(), 0);
        check("w_q_empty", w_q.size(), 0);
        check("b_q_empty", b_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
